// File: rtl/exmem_register_pkg.sv
// Shared CPU types for the EX/MEM pipeline register: word and register-select
// widths and the packed payload carried from EX into MEM.
package exmem_register_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    word_t    pc4;
    word_t    aluout;
    word_t    storedata;
    regbits_t wsel;
    logic     regen;
    logic     dren;
    logic     dwen;
    logic     memtoreg;
    logic     halt;
  } exmem_t;

endpackage : exmem_register_pkg

// File: rtl/exmem_register_if.sv
// Signal bundle between the EX stage, the EX/MEM register and its consumers
// (forwarding, MEM/WB, data cache).
interface exmem_register_if;
  import exmem_register_pkg::*;

  logic     en;
  logic     flush;
  logic     dhit;

  word_t    idex_pc4;
  word_t    idex_aluout;
  word_t    idex_storedata;
  regbits_t idex_wsel;
  logic     idex_regen;
  logic     idex_dren;
  logic     idex_dwen;
  logic     idex_memtoreg;
  logic     idex_halt;

  word_t    exmem_pc4;
  word_t    exmem_aluout;
  word_t    exmem_storedata;
  regbits_t exmemwsel;
  logic     exmemregen;
  logic     exmem_memtoreg;
  logic     exmem_halt;
  logic     dmemren;
  logic     dmemwen;

  modport slave (
    input  en, flush, dhit,
    input  idex_pc4, idex_aluout, idex_storedata, idex_wsel,
    input  idex_regen, idex_dren, idex_dwen, idex_memtoreg, idex_halt,
    output exmem_pc4, exmem_aluout, exmem_storedata, exmemwsel,
    output exmemregen, exmem_memtoreg, exmem_halt, dmemren, dmemwen
  );

  modport master (
    output en, flush, dhit,
    output idex_pc4, idex_aluout, idex_storedata, idex_wsel,
    output idex_regen, idex_dren, idex_dwen, idex_memtoreg, idex_halt,
    input  exmem_pc4, exmem_aluout, exmem_storedata, exmemwsel,
    input  exmemregen, exmem_memtoreg, exmem_halt, dmemren, dmemwen
  );

endinterface : exmem_register_if

// File: rtl/exmem_register.sv
// EX/MEM pipeline register: one-cycle latch of the EX payload with bubble
// insertion on flush, request retirement on dhit and a sticky halt flag.
module exmem_register
  import exmem_register_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  exmem_register_if.slave  bus
);

  exmem_t exmem_q;
  exmem_t exmem_d;
  exmem_t load;

  // Incoming payload, normalised: no $zero writeback, and a request with both
  // read and write set is a store.
  always_comb begin
    load           = '0;
    load.pc4       = bus.idex_pc4;
    load.aluout    = bus.idex_aluout;
    load.storedata = bus.idex_storedata;
    load.wsel      = bus.idex_wsel;
    load.regen     = bus.idex_regen && (bus.idex_wsel != '0);
    load.dwen      = bus.idex_dwen;
    load.dren      = bus.idex_dren && !bus.idex_dwen;
    load.memtoreg  = bus.idex_memtoreg;
    load.halt      = exmem_q.halt | bus.idex_halt;
  end

  // NOTE: exmem_d takes a full default first so no path through the priority
  // chain leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    exmem_d = exmem_q;
    if (bus.en && bus.flush) begin
      exmem_d      = '0;
      exmem_d.halt = exmem_q.halt;
    end else if (bus.en) begin
      exmem_d = load;
    end else if (bus.dhit) begin
      exmem_d.dren = 1'b0;
      exmem_d.dwen = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every reader in
  // this cycle sees the pre-edge value regardless of evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign bus.exmem_pc4       = exmem_q.pc4;
  assign bus.exmem_aluout    = exmem_q.aluout;
  assign bus.exmem_storedata = exmem_q.storedata;
  assign bus.exmemwsel       = exmem_q.wsel;
  assign bus.exmemregen      = exmem_q.regen;
  assign bus.exmem_memtoreg  = exmem_q.memtoreg;
  assign bus.exmem_halt      = exmem_q.halt;
  assign bus.dmemren         = exmem_q.dren;
  assign bus.dmemwen         = exmem_q.dwen;

endmodule : exmem_register

// File: tb/tb_exmem_register.sv
// Self-checking bench for exmem_register: vector table through a scoreboard
// queue, plus hand sequences for asynchronous reset during a pending request.
module tb_exmem_register;
  import exmem_register_pkg::*;

  typedef struct packed {
    logic     en;
    logic     flush;
    logic     dhit;
    word_t    pc4;
    word_t    alu;
    word_t    sd;
    regbits_t wsel;
    logic     regen;
    logic     dren;
    logic     dwen;
    logic     m2r;
    logic     halt;
  } in_t;

  typedef struct packed {
    word_t    pc4;
    word_t    alu;
    word_t    sd;
    regbits_t wsel;
    logic     regen;
    logic     m2r;
    logic     halt;
    logic     ren;
    logic     wen;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  logic CLK;
  logic nRST;
  exmem_register_if bus ();

  exmem_register dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  out_t sb[$];
  vec_t vecs[$];

  function automatic in_t mk_in(logic en, logic flush, logic dhit, word_t pc4,
                                word_t alu, word_t sd, regbits_t wsel, logic regen,
                                logic dren, logic dwen, logic m2r, logic halt);
    in_t r;
    r = '{en, flush, dhit, pc4, alu, sd, wsel, regen, dren, dwen, m2r, halt};
    return r;
  endfunction

  function automatic out_t mk_out(word_t pc4, word_t alu, word_t sd, regbits_t wsel,
                                  logic regen, logic m2r, logic halt, logic ren,
                                  logic wen);
    out_t r;
    r = '{pc4, alu, sd, wsel, regen, m2r, halt, ren, wen};
    return r;
  endfunction

  function automatic out_t sample();
    out_t r;
    r = '{bus.exmem_pc4, bus.exmem_aluout, bus.exmem_storedata, bus.exmemwsel,
          bus.exmemregen, bus.exmem_memtoreg, bus.exmem_halt, bus.dmemren, bus.dmemwen};
    return r;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got pc4=%h alu=%h sd=%h wsel=%0d regen=%b m2r=%b halt=%b ren=%b wen=%b",
               name, got.pc4, got.alu, got.sd, got.wsel, got.regen, got.m2r, got.halt,
               got.ren, got.wen);
      $display("     %s: exp pc4=%h alu=%h sd=%h wsel=%0d regen=%b m2r=%b halt=%b ren=%b wen=%b",
               name, exp.pc4, exp.alu, exp.sd, exp.wsel, exp.regen, exp.m2r, exp.halt,
               exp.ren, exp.wen);
    end
  endtask

  task automatic drive(input in_t v);
    bus.en             = v.en;
    bus.flush          = v.flush;
    bus.dhit           = v.dhit;
    bus.idex_pc4       = v.pc4;
    bus.idex_aluout    = v.alu;
    bus.idex_storedata = v.sd;
    bus.idex_wsel      = v.wsel;
    bus.idex_regen     = v.regen;
    bus.idex_dren      = v.dren;
    bus.idex_dwen      = v.dwen;
    bus.idex_memtoreg  = v.m2r;
    bus.idex_halt      = v.halt;
  endtask

  // Drive on the falling edge, record the expectation, compare 1 ns after the
  // next rising edge.
  task automatic apply(input string name, input in_t v, input out_t e);
    out_t exp;
    @(negedge CLK);
    drive(v);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    exp = sb.pop_front();
    check(name, sample(), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    out_t zero;
    zero = '0;

    // Table: each row's expectation follows from the rows before it.
    vecs.push_back('{mk_in(1,0,0,'h4,'h1234,'h0,5'd8,1,0,0,0,0),
                     mk_out('h4,'h1234,'h0,5'd8,1,0,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,'hDEAD0000,'hFFFF,'h1111,5'd5,1,1,1,1,1),
                     mk_out('h4,'h1234,'h0,5'd8,1,0,0,0,0)});
    vecs.push_back('{mk_in(1,0,0,'h8,'h100,'h0,5'd9,1,1,0,1,0),
                     mk_out('h8,'h100,'h0,5'd9,1,1,0,1,0)});
    vecs.push_back('{mk_in(0,0,1,'hAAAA,'hBBBB,'hCCCC,5'd7,0,0,1,0,0),
                     mk_out('h8,'h100,'h0,5'd9,1,1,0,0,0)});
    vecs.push_back('{mk_in(0,0,0,'hAAAA,'hBBBB,'hCCCC,5'd7,0,0,1,0,0),
                     mk_out('h8,'h100,'h0,5'd9,1,1,0,0,0)});
    vecs.push_back('{mk_in(1,0,0,'hC,'h55,'h0,5'd0,1,0,0,0,0),
                     mk_out('hC,'h55,'h0,5'd0,0,0,0,0,0)});
    vecs.push_back('{mk_in(1,0,0,'h10,'h200,'hCAFE,5'd3,0,1,1,0,0),
                     mk_out('h10,'h200,'hCAFE,5'd3,0,0,0,0,1)});
    vecs.push_back('{mk_in(1,0,1,'h14,'h300,'hBEEF,5'd0,0,0,1,0,0),
                     mk_out('h14,'h300,'hBEEF,5'd0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,1,0,'h99,'h999,'h999,5'd4,1,1,0,1,1),
                     mk_out('h14,'h300,'hBEEF,5'd0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,0,1,'h99,'h999,'h999,5'd4,1,1,0,1,1),
                     mk_out('h14,'h300,'hBEEF,5'd0,0,0,0,0,0)});
    vecs.push_back('{mk_in(1,0,0,'h18,'h7,'h0,5'd31,1,0,0,0,1),
                     mk_out('h18,'h7,'h0,5'd31,1,0,1,0,0)});
    vecs.push_back('{mk_in(1,0,0,'h1C,'h8,'h0,5'd2,1,1,0,0,0),
                     mk_out('h1C,'h8,'h0,5'd2,1,0,1,1,0)});
    vecs.push_back('{mk_in(1,1,0,'h20,'hABC,'hDEF,5'd6,1,1,0,1,0),
                     mk_out('h0,'h0,'h0,5'd0,0,0,1,0,0)});
    vecs.push_back('{mk_in(1,1,1,'h24,'hABC,'hDEF,5'd6,1,0,1,1,0),
                     mk_out('h0,'h0,'h0,5'd0,0,0,1,0,0)});

    // Reset asserted from time zero: outputs must clear before any edge.
    nRST = 1'b0;
    drive('0);
    #2;
    check("reset_async_initial", sample(), zero);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    apply("reset_idle", '0, zero);

    foreach (vecs[k]) begin
      apply($sformatf("vec%0d", k), vecs[k].i, vecs[k].e);
    end

    // Pending read request, then reset pulsed between edges.
    apply("pre_reset_load", mk_in(1,0,0,'h40,'h4444,'h0,5'd10,1,1,0,1,0),
          mk_out('h40,'h4444,'h0,5'd10,1,1,1,1,0));
    drive('0);
    #3;
    nRST = 1'b0;
    #1;
    check("reset_async_mid_request", sample(), zero);
    @(posedge CLK);
    #1;
    check("reset_held_over_edge", sample(), zero);
    @(negedge CLK);
    nRST = 1'b1;
    apply("post_reset_idle", '0, zero);
    apply("post_reset_dhit", mk_in(0,0,1,'h0,'h0,'h0,5'd0,0,0,0,0,0), zero);
    apply("post_reset_flush_no_en", mk_in(0,1,0,'h48,'h1,'h2,5'd3,1,1,0,1,1), zero);
    apply("post_reset_load", mk_in(1,0,0,'h44,'h5555,'h0,5'd11,1,0,0,0,0),
          mk_out('h44,'h5555,'h0,5'd11,1,0,0,0,0));

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_exmem_register
